// File: rtl/commutator_pkg.sv
// Shared sizing and helpers for the 5-to-3 commutator grant controller.
package commutator_pkg;

  localparam int N_IN  = 5;
  localparam int N_OUT = 3;
  localparam int SEL_W = 3;
  localparam int CH_W  = $clog2(N_OUT);

  // Select value driven on an idle channel.
  localparam logic [SEL_W-1:0] NO_SRC  = {SEL_W{1'b0}};
  // Pointer value after reset so that the first search begins at input 0.
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N_IN - 1);

  // Binary index of a one-hot input vector (zero when no bit is set).
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_IN-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/commutator_ctrl_if.sv
// Request/grant and channel-configuration bundle between requesters and the controller.
interface commutator_ctrl_if;
  import commutator_pkg::*;

  logic [N_IN-1:0]        req;
  logic [N_IN-1:0]        rel;
  logic [N_IN-1:0]        gnt;
  logic [N_OUT-1:0]       ch_vld;
  logic [N_OUT*SEL_W-1:0] ch_sel;
  logic                   all_busy;

  // Requester side.
  modport master (
    output req, rel,
    input  gnt, ch_vld, ch_sel, all_busy
  );

  // Controller side.
  modport slave (
    input  req, rel,
    output gnt, ch_vld, ch_sel, all_busy
  );

endinterface

// File: rtl/commutator_ctrl_rr_pick.sv
// Round-robin picker: first set candidate after the pointer, wrapping modulo N.
module rr_pick #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] win,
  output logic         any_valid
);

  assign any_valid = |cand;

  // Search ptr+1, ptr+2, ... ptr+N; the last step revisits ptr itself.
  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (int'(ptr) + off) % N;
      if (!found && cand[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/commutator_ctrl.sv
// Grant controller for the 5-to-3 commutator: allocates free output channels
// to requesting inputs round-robin, one per cycle, and holds each grant until
// the input releases it. Channel registers directly configure the mux datapath.
module commutator_ctrl
  import commutator_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  commutator_ctrl_if.slave   bus
);

  logic [N_IN-1:0]  gnt_p0;
  logic [N_OUT-1:0] ch_vld_p0;
  logic [SEL_W-1:0] ch_sel_p0 [N_OUT];
  logic [SEL_W-1:0] ptr_p0;

  logic [N_IN-1:0]  gnt_nxt;
  logic [N_OUT-1:0] ch_vld_nxt;
  logic [SEL_W-1:0] ch_sel_nxt [N_OUT];
  logic [SEL_W-1:0] ptr_nxt;

  logic [N_IN-1:0]  cand;
  logic [N_IN-1:0]  rel_eff;
  logic [N_IN-1:0]  win_oh;
  logic             any_cand;
  logic [SEL_W-1:0] win_idx;
  logic [CH_W-1:0]  free_k;
  logic             have_free;
  logic             alloc;
  logic [N_OUT-1:0] ch_rel;

  // A release in the same cycle disqualifies the input, so release beats re-request.
  assign cand    = bus.req & ~gnt_p0 & ~bus.rel;
  assign rel_eff = bus.rel & gnt_p0;

  rr_pick #(
    .N (N_IN),
    .W (SEL_W)
  ) u_pick (
    .cand      (cand),
    .ptr       (ptr_p0),
    .win       (win_oh),
    .any_valid (any_cand)
  );

  assign win_idx = onehot_to_idx(win_oh);
  assign alloc   = any_cand & have_free;

  // Lowest-indexed idle channel, judged on start-of-cycle state only.
  always_comb begin
    have_free = 1'b0;
    free_k    = '0;
    for (int k = N_OUT - 1; k >= 0; k--) begin
      if (!ch_vld_p0[k]) begin
        have_free = 1'b1;
        free_k    = CH_W'(k);
      end
    end
  end

  // Map each honoured release onto the channel currently carrying that input.
  always_comb begin
    ch_rel = '0;
    for (int k = 0; k < N_OUT; k++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (ch_vld_p0[k] && rel_eff[i] && (ch_sel_p0[k] == SEL_W'(i))) ch_rel[k] = 1'b1;
      end
    end
  end

  // Next grant/channel state: releases clear, then at most one new allocation.
  always_comb begin
    gnt_nxt = gnt_p0 & ~rel_eff;
    if (alloc) gnt_nxt = gnt_nxt | win_oh;
    ptr_nxt = alloc ? win_idx : ptr_p0;
    for (int k = 0; k < N_OUT; k++) begin
      ch_vld_nxt[k] = ch_vld_p0[k];
      ch_sel_nxt[k] = ch_sel_p0[k];
      if (ch_rel[k]) begin
        ch_vld_nxt[k] = 1'b0;
        ch_sel_nxt[k] = NO_SRC;
      end
      if (alloc && (free_k == CH_W'(k))) begin
        ch_vld_nxt[k] = 1'b1;
        ch_sel_nxt[k] = win_idx;
      end
    end
  end

  // State registers; reset drops every grant immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_p0    <= '0;
      ch_vld_p0 <= '0;
      ptr_p0    <= PTR_RST;
      for (int k = 0; k < N_OUT; k++) ch_sel_p0[k] <= NO_SRC;
    end else begin
      gnt_p0    <= gnt_nxt;
      ch_vld_p0 <= ch_vld_nxt;
      ptr_p0    <= ptr_nxt;
      for (int k = 0; k < N_OUT; k++) ch_sel_p0[k] <= ch_sel_nxt[k];
    end
  end

  assign bus.gnt      = gnt_p0;
  assign bus.ch_vld   = ch_vld_p0;
  assign bus.all_busy = &ch_vld_p0;

  for (genvar k = 0; k < N_OUT; k++) begin : g_sel
    assign bus.ch_sel[k*SEL_W +: SEL_W] = ch_sel_p0[k];
  end

endmodule

// File: tb/tb_commutator_ctrl.sv
// Directed bench for the commutator grant controller.
module tb_commutator_ctrl;
  import commutator_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  commutator_ctrl_if bus();

  commutator_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = '0; bus.rel = '0;
    tick(); tick();
    checks++; if (bus.gnt !== 5'b00000) begin errors++; $display("FAIL reset_gnt: got %b want %b", bus.gnt, 5'b00000); end
    checks++; if (bus.ch_vld !== 3'b000) begin errors++; $display("FAIL reset_vld: got %b want %b", bus.ch_vld, 3'b000); end
    checks++; if (bus.ch_sel !== 9'd0) begin errors++; $display("FAIL reset_sel: got %h want %h", bus.ch_sel, 9'd0); end
    checks++; if (bus.all_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want %b", bus.all_busy, 1'b0); end
  endtask

  task automatic test_first_grant();
    rst = 1'b0;
    bus.req = 5'b00001;
    #1;
    checks++; if (bus.gnt !== 5'b00000) begin errors++; $display("FAIL first_early: got %b want %b", bus.gnt, 5'b00000); end
    tick();
    checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL first_gnt: got %b want %b", bus.gnt, 5'b00001); end
    checks++; if (bus.ch_vld !== 3'b001) begin errors++; $display("FAIL first_vld: got %b want %b", bus.ch_vld, 3'b001); end
    checks++; if (bus.ch_sel !== 9'd0) begin errors++; $display("FAIL first_sel: got %h want %h", bus.ch_sel, 9'd0); end
  endtask

  task automatic test_fill();
    rst = 1'b1; bus.req = '0; bus.rel = '0;
    tick();
    rst = 1'b0; bus.req = 5'b11111;
    tick();
    checks++; if ({bus.gnt, bus.ch_vld} !== {5'b00001, 3'b001}) begin errors++; $display("FAIL fill_1: got %b/%b want 00001/001", bus.gnt, bus.ch_vld); end
    tick();
    checks++; if ({bus.gnt, bus.ch_vld} !== {5'b00011, 3'b011}) begin errors++; $display("FAIL fill_2: got %b/%b want 00011/011", bus.gnt, bus.ch_vld); end
    tick();
    checks++; if ({bus.gnt, bus.ch_vld} !== {5'b00111, 3'b111}) begin errors++; $display("FAIL fill_3: got %b/%b want 00111/111", bus.gnt, bus.ch_vld); end
    checks++; if (bus.ch_sel !== {3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL fill_sel: got %h want %h", bus.ch_sel, {3'd2, 3'd1, 3'd0}); end
    checks++; if (bus.all_busy !== 1'b1) begin errors++; $display("FAIL fill_busy: got %b want %b", bus.all_busy, 1'b1); end
    tick(); tick();
    checks++; if (bus.gnt !== 5'b00111) begin errors++; $display("FAIL fill_hold: got %b want %b", bus.gnt, 5'b00111); end
  endtask

  task automatic test_release_regrant();
    bus.rel = 5'b00010;
    tick();
    bus.rel = '0;
    checks++; if ({bus.gnt, bus.ch_vld} !== {5'b00101, 3'b101}) begin errors++; $display("FAIL rel1_state: got %b/%b want 00101/101", bus.gnt, bus.ch_vld); end
    checks++; if (bus.ch_sel !== {3'd2, 3'd0, 3'd0}) begin errors++; $display("FAIL rel1_sel: got %h want %h", bus.ch_sel, {3'd2, 3'd0, 3'd0}); end
    checks++; if (bus.all_busy !== 1'b0) begin errors++; $display("FAIL rel1_busy: got %b want %b", bus.all_busy, 1'b0); end
    tick();
    checks++; if ({bus.gnt, bus.ch_vld} !== {5'b01101, 3'b111}) begin errors++; $display("FAIL regrant3: got %b/%b want 01101/111", bus.gnt, bus.ch_vld); end
    checks++; if (bus.ch_sel !== {3'd2, 3'd3, 3'd0}) begin errors++; $display("FAIL regrant3_sel: got %h want %h", bus.ch_sel, {3'd2, 3'd3, 3'd0}); end
  endtask

  task automatic test_rel_and_new_req();
    bus.rel = 5'b00001;
    tick();
    bus.rel = '0;
    checks++; if ({bus.gnt, bus.ch_vld} !== {5'b01100, 3'b110}) begin errors++; $display("FAIL rel0_state: got %b/%b want 01100/110", bus.gnt, bus.ch_vld); end
    tick();
    checks++; if ({bus.gnt, bus.ch_vld} !== {5'b11100, 3'b111}) begin errors++; $display("FAIL grant4: got %b/%b want 11100/111", bus.gnt, bus.ch_vld); end
    checks++; if (bus.ch_sel !== {3'd2, 3'd3, 3'd4}) begin errors++; $display("FAIL grant4_sel: got %h want %h", bus.ch_sel, {3'd2, 3'd3, 3'd4}); end
  endtask

  task automatic test_ignored_events();
    bus.req = '0; bus.rel = 5'b00001;
    tick();
    bus.rel = '0; bus.req = 5'b00010;
    tick();
    bus.req = '0;
    tick();
    checks++; if ({bus.gnt, bus.ch_vld, bus.ch_sel} !== {5'b11100, 3'b111, 3'd2, 3'd3, 3'd4}) begin errors++; $display("FAIL ignore_state: got %b/%b/%h want 11100/111/%h", bus.gnt, bus.ch_vld, bus.ch_sel, {3'd2, 3'd3, 3'd4}); end
    bus.rel = 5'b00100;
    tick();
    bus.rel = '0;
    checks++; if ({bus.gnt, bus.ch_vld} !== {5'b11000, 3'b011}) begin errors++; $display("FAIL rel2_state: got %b/%b want 11000/011", bus.gnt, bus.ch_vld); end
    tick(); tick();
    checks++; if ({bus.gnt, bus.ch_vld, bus.ch_sel} !== {5'b11000, 3'b011, 3'd0, 3'd3, 3'd4}) begin errors++; $display("FAIL dropped_req: got %b/%b/%h want 11000/011/%h", bus.gnt, bus.ch_vld, bus.ch_sel, {3'd0, 3'd3, 3'd4}); end
  endtask

  task automatic test_rel_wins();
    bus.req = 5'b01000; bus.rel = 5'b01000;
    tick();
    bus.rel = '0;
    checks++; if ({bus.gnt, bus.ch_vld} !== {5'b10000, 3'b001}) begin errors++; $display("FAIL relwin_state: got %b/%b want 10000/001", bus.gnt, bus.ch_vld); end
    tick();
    checks++; if ({bus.gnt, bus.ch_vld, bus.ch_sel} !== {5'b11000, 3'b011, 3'd0, 3'd3, 3'd4}) begin errors++; $display("FAIL relwin_regrant: got %b/%b/%h want 11000/011/%h", bus.gnt, bus.ch_vld, bus.ch_sel, {3'd0, 3'd3, 3'd4}); end
  endtask

  task automatic test_back_to_back();
    bus.req = 5'b00001; bus.rel = 5'b10000;
    tick();
    bus.rel = '0;
    checks++; if ({bus.gnt, bus.ch_vld, bus.ch_sel} !== {5'b01001, 3'b110, 3'd0, 3'd3, 3'd0}) begin errors++; $display("FAIL b2b_state: got %b/%b/%h want 01001/110/%h", bus.gnt, bus.ch_vld, bus.ch_sel, {3'd0, 3'd3, 3'd0}); end
    bus.req = 5'b00011;
    tick();
    checks++; if ({bus.gnt, bus.ch_vld, bus.ch_sel} !== {5'b01011, 3'b111, 3'd0, 3'd3, 3'd1}) begin errors++; $display("FAIL b2b_fill: got %b/%b/%h want 01011/111/%h", bus.gnt, bus.ch_vld, bus.ch_sel, {3'd0, 3'd3, 3'd1}); end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    checks++; if ({bus.gnt, bus.ch_vld, bus.ch_sel, bus.all_busy} !== 18'd0) begin errors++; $display("FAIL midrst_state: got %b/%b/%h/%b want all zero", bus.gnt, bus.ch_vld, bus.ch_sel, bus.all_busy); end
    rst = 1'b0; bus.req = 5'b11111;
    tick();
    checks++; if ({bus.gnt, bus.ch_vld, bus.ch_sel} !== {5'b00001, 3'b001, 9'd0}) begin errors++; $display("FAIL midrst_first: got %b/%b/%h want 00001/001/000", bus.gnt, bus.ch_vld, bus.ch_sel); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req = '0;
    bus.rel = '0;
    test_reset();
    test_first_grant();
    test_fill();
    test_release_regrant();
    test_rel_and_new_req();
    test_ignored_events();
    test_rel_wins();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
